// File: rtl/pwm_burst_sequencer.sv
// pwm_burst_sequencer: burst command sequencer for the dead-time PWM generator.
// Shadows one timing set per burst and strobes the generator once per pulse.
`timescale 1ns/1ps
module pwm_burst_sequencer #(
  parameter int _RAM_WIDTH     = 32,
  parameter int CNT_WIDTH      = 16,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                  io_clk,
  input  logic                  io_rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [_RAM_WIDTH-1:0] cfg_pulse_period,
  input  logic [_RAM_WIDTH-1:0] cfg_die_period,
  input  logic [_RAM_WIDTH-1:0] cfg_gap,
  input  logic [CNT_WIDTH-1:0]  cfg_pulse_count,
  input  logic                  cfg_default_level,
  input  logic                  pulse_valid,
  output logic                  pwm_en,
  output logic                  pwm_dis,
  output logic [_RAM_WIDTH-1:0] pulse_period,
  output logic [_RAM_WIDTH-1:0] die_period,
  output logic                  io_defaultLevel,
  output logic                  busy,
  output logic                  done,
  output logic                  timeout_err,
  output logic [CNT_WIDTH-1:0]  pulses_done
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_FIRE = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_GAP  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam int WD_W = (TIMEOUT_CYCLES > 1) ?
                        $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [WD_W-1:0] WD_LAST =
    WD_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam bit WD_ON = (TIMEOUT_CYCLES != 0);

  logic [2:0]            state;
  logic [CNT_WIDTH-1:0]  cnt_sh;
  logic [_RAM_WIDTH-1:0] gap_sh;
  logic [_RAM_WIDTH-1:0] gap_cnt;
  logic [WD_W-1:0]       wd_cnt;
  logic [CNT_WIDTH-1:0]  pd_inc;
  logic                  wd_hit;

  assign pd_inc = (&pulses_done) ? pulses_done : pulses_done + 1'b1;
  assign wd_hit = WD_ON && (wd_cnt == WD_LAST);

  always_ff @(posedge io_clk) begin
    if (io_rst) begin
      state           <= S_IDLE;
      pwm_en          <= 1'b0;
      pwm_dis         <= 1'b0;
      done            <= 1'b0;
      busy            <= 1'b0;
      timeout_err     <= 1'b0;
      pulses_done     <= '0;
      pulse_period    <= '0;
      die_period      <= '0;
      io_defaultLevel <= 1'b0;
      cnt_sh          <= '0;
      gap_sh          <= '0;
      gap_cnt         <= '0;
      wd_cnt          <= '0;
    end else begin
      pwm_en  <= 1'b0;
      pwm_dis <= 1'b0;
      done    <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            if (cfg_pulse_count != '0) begin
              pulse_period    <= cfg_pulse_period;
              die_period      <= cfg_die_period;
              io_defaultLevel <= cfg_default_level;
              cnt_sh          <= cfg_pulse_count;
              gap_sh          <= cfg_gap;
              pulses_done     <= '0;
              timeout_err     <= 1'b0;
              pwm_en          <= 1'b1;
              busy            <= 1'b1;
              state           <= S_FIRE;
            end else begin
              done <= 1'b1;
            end
          end
        end
        S_FIRE: begin
          if (abort) begin
            pwm_dis <= 1'b1;
            busy    <= 1'b0;
            state   <= S_IDLE;
          end else begin
            wd_cnt <= '0;
            state  <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (abort) begin
            pwm_dis <= 1'b1;
            busy    <= 1'b0;
            state   <= S_IDLE;
          end else if (wd_hit) begin
            pwm_dis     <= 1'b1;
            timeout_err <= 1'b1;
            busy        <= 1'b0;
            state       <= S_IDLE;
          end else if (pulse_valid) begin
            wd_cnt      <= '0;
            pulses_done <= pd_inc;
            if (pd_inc == cnt_sh) begin
              done  <= 1'b1;
              state <= S_DONE;
            end else if (gap_sh == '0) begin
              pwm_en <= 1'b1;
              state  <= S_FIRE;
            end else begin
              gap_cnt <= gap_sh;
              state   <= S_GAP;
            end
          end else if (WD_ON) begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        S_GAP: begin
          if (abort) begin
            pwm_dis <= 1'b1;
            busy    <= 1'b0;
            state   <= S_IDLE;
          end else if (gap_cnt == _RAM_WIDTH'(1)) begin
            pwm_en <= 1'b1;
            state  <= S_FIRE;
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_burst_sequencer.sv
// tb_pwm_burst_sequencer: directed bursts with an event scoreboard.
// Strobe events are queued by the stimulus and popped by the monitor.
`timescale 1ns/1ps
module tb_pwm_burst_sequencer;

  logic        io_clk = 1'b0;
  logic        io_rst = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [31:0] cfg_pulse_period = '0;
  logic [31:0] cfg_die_period = '0;
  logic [31:0] cfg_gap = '0;
  logic [15:0] cfg_pulse_count = '0;
  logic        cfg_default_level = 1'b0;
  logic        pulse_valid = 1'b0;
  logic        pwm_en;
  logic        pwm_dis;
  logic [31:0] pulse_period;
  logic [31:0] die_period;
  logic        io_defaultLevel;
  logic        busy;
  logic        done;
  logic        timeout_err;
  logic [15:0] pulses_done;

  pwm_burst_sequencer #(
    ._RAM_WIDTH(32), .CNT_WIDTH(16), .TIMEOUT_CYCLES(50)
  ) dut (
    .io_clk(io_clk), .io_rst(io_rst), .start(start), .abort(abort),
    .cfg_pulse_period(cfg_pulse_period), .cfg_die_period(cfg_die_period),
    .cfg_gap(cfg_gap), .cfg_pulse_count(cfg_pulse_count),
    .cfg_default_level(cfg_default_level), .pulse_valid(pulse_valid),
    .pwm_en(pwm_en), .pwm_dis(pwm_dis), .pulse_period(pulse_period),
    .die_period(die_period), .io_defaultLevel(io_defaultLevel),
    .busy(busy), .done(done), .timeout_err(timeout_err),
    .pulses_done(pulses_done)
  );

  always #2.5 io_clk = ~io_clk;

  localparam int K_EN = 1, K_DIS = 2, K_DONE = 4;

  typedef struct {
    int kind; int cyc; int pd; bit te; bit bz;
    bit sh; int per; int die;
  } ev_t;

  ev_t q[$];
  int  cyc = 0;
  int  checks = 0;
  int  errors = 0;

  always @(posedge io_clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %0d expected %0d", nm, cyc, act, exp);
    end
  endtask

  task automatic ev(input int k, input int c, input int pd, input bit te,
                    input bit bz, input bit sh, input int per, input int die);
    ev_t e;
    e.kind = k; e.cyc = c; e.pd = pd; e.te = te; e.bz = bz;
    e.sh = sh; e.per = per; e.die = die;
    q.push_back(e);
  endtask

  always @(negedge io_clk) begin
    if (!io_rst && (pwm_en || pwm_dis || done)) begin
      if (q.size() == 0) begin
        chk("unexpected_strobe", {29'd0, done, pwm_dis, pwm_en}, 0);
      end else begin
        ev_t e;
        e = q.pop_front();
        chk("ev_kind", {29'd0, done, pwm_dis, pwm_en}, e.kind);
        chk("ev_cycle", cyc, e.cyc);
        chk("ev_pulses_done", pulses_done, e.pd);
        chk("ev_timeout_err", timeout_err, e.te);
        chk("ev_busy", busy, e.bz);
        if (e.sh) begin
          chk("ev_pulse_period", pulse_period, e.per);
          chk("ev_die_period", die_period, e.die);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge io_clk);
    #1;
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) tick(1);
  endtask

  task automatic start_at(input int s, input int cnt, input int gap,
                          input int per, input int die, input bit lvl);
    wait_to(s - 1);
    cfg_pulse_count = 16'(cnt);
    cfg_gap = 32'(gap);
    cfg_pulse_period = 32'(per);
    cfg_die_period = 32'(die);
    cfg_default_level = lvl;
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic pv_at(input int p);
    wait_to(p - 1);
    pulse_valid = 1'b1;
    tick(1);
    pulse_valid = 1'b0;
  endtask

  task automatic abort_at(input int p, input bit with_pv);
    wait_to(p - 1);
    abort = 1'b1;
    pulse_valid = with_pv;
    tick(1);
    abort = 1'b0;
    pulse_valid = 1'b0;
  endtask

  initial begin
    #100us;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    wait_to(40);
    io_rst = 1'b0;
    tick(2);
    chk("rst_pwm_en", pwm_en, 0);
    chk("rst_pwm_dis", pwm_dis, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_timeout_err", timeout_err, 0);
    chk("rst_pulses_done", pulses_done, 0);
    chk("rst_pulse_period", pulse_period, 0);
    chk("rst_level", io_defaultLevel, 0);

    // three pulses, no gap
    ev(K_EN, 50, 0, 0, 1, 1, 5, 3);
    ev(K_EN, 70, 1, 0, 1, 1, 5, 3);
    ev(K_EN, 90, 2, 0, 1, 1, 5, 3);
    ev(K_DONE, 110, 3, 0, 1, 1, 5, 3);
    start_at(50, 3, 0, 5, 3, 1);
    pv_at(70);
    pv_at(90);
    pv_at(110);
    pv_at(115);
    wait_to(118);
    chk("a_pulses_done", pulses_done, 3);
    chk("a_busy", busy, 0);
    chk("a_level", io_defaultLevel, 1);

    // gap of 4, restart attempt and pulse_valid during GAP ignored
    ev(K_EN, 130, 0, 0, 1, 1, 7, 2);
    ev(K_EN, 154, 1, 0, 1, 1, 7, 2);
    ev(K_DONE, 174, 2, 0, 1, 1, 7, 2);
    start_at(130, 2, 4, 7, 2, 0);
    start_at(140, 3, 0, 99, 9, 1);
    pv_at(150);
    pv_at(152);
    pv_at(174);
    wait_to(176);
    chk("b_pulse_period", pulse_period, 7);
    chk("b_die_period", die_period, 2);
    chk("b_level", io_defaultLevel, 0);

    // abort together with a pulse_valid, then a clean single pulse
    ev(K_EN, 190, 0, 0, 1, 1, 11, 4);
    ev(K_EN, 210, 1, 0, 1, 1, 11, 4);
    ev(K_EN, 230, 2, 0, 1, 1, 11, 4);
    ev(K_DIS, 231, 2, 0, 0, 1, 11, 4);
    start_at(190, 5, 0, 11, 4, 1);
    pv_at(210);
    pv_at(230);
    abort_at(231, 1'b1);
    wait_to(234);
    chk("c_busy", busy, 0);
    chk("c_pulses_done", pulses_done, 2);
    abort_at(236, 1'b0);
    ev(K_EN, 240, 0, 0, 1, 1, 6, 2);
    ev(K_DONE, 260, 1, 0, 1, 1, 6, 2);
    start_at(240, 1, 0, 6, 2, 0);
    pv_at(260);

    // zero-count start
    ev(K_DONE, 270, 1, 0, 0, 0, 0, 0);
    start_at(270, 0, 0, 77, 77, 1);

    // watchdog: no pulse_valid, WAIT entered at edge 281
    ev(K_EN, 280, 0, 0, 1, 1, 13, 1);
    ev(K_DIS, 331, 0, 1, 0, 1, 13, 1);
    start_at(280, 2, 0, 13, 1, 1);
    wait_to(340);
    chk("d_timeout_sticky", timeout_err, 1);
    chk("d_busy", busy, 0);
    ev(K_EN, 350, 0, 0, 1, 1, 6, 2);
    ev(K_DONE, 370, 1, 0, 1, 1, 6, 2);
    start_at(350, 1, 0, 6, 2, 0);
    chk("d_timeout_clear", timeout_err, 0);
    pv_at(370);

    // reset in the middle of a gap suppresses the pending strobe
    ev(K_EN, 380, 0, 0, 1, 1, 5, 3);
    start_at(380, 3, 10, 5, 3, 1);
    pv_at(400);
    wait_to(404);
    io_rst = 1'b1;
    tick(1);
    chk("e_busy", busy, 0);
    chk("e_pulses_done", pulses_done, 0);
    chk("e_pulse_period", pulse_period, 0);
    chk("e_die_period", die_period, 0);
    chk("e_level", io_defaultLevel, 0);
    chk("e_strobes", {pwm_en, pwm_dis, done}, 0);
    tick(2);
    io_rst = 1'b0;
    wait_to(430);
    chk("e_no_strobe_after_rst", {pwm_en, pwm_dis, done, busy}, 0);
    chk("pending_events", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
